// File: rtl/nios2_system_v0_pio_pkg.sv
// Shared definitions for the Nios II PIO-style status ports:
// register offsets and edge-type selection.
package nios2_system_v0_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK    = 2'd2;
  localparam logic [1:0] PIO_ADDR_CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

endpackage

// File: rtl/nios2_system_v0_done_bit_in_if.sv
// Avalon-MM slave bus for the done-bit input port, including the irq line.
interface nios2_system_v0_done_bit_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios2_system_v0_sync_edge_det.sv
// One-bit synchroniser followed by a previous-sample register and an
// edge pulse of the selected type (rising, falling or any).
module nios2_system_v0_sync_edge_det
  import nios2_system_v0_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic edge_pulse
);

  localparam logic [1:0] EDGE_BITS = EDGE_TYPE[1:0];
  localparam edge_type_e EDGE_SEL  = edge_type_e'(EDGE_BITS);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchroniser chain and one-cycle-delayed sample of its output
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  // Edge pulse for the configured polarity
  always_comb begin
    edge_pulse = 1'b0;
    case (EDGE_SEL)
      EDGE_RISING:  edge_pulse = sync & ~prev;
      EDGE_FALLING: edge_pulse = ~sync & prev;
      EDGE_ANY:     edge_pulse = sync ^ prev;
      default:      edge_pulse = 1'b0;
    endcase
  end

endmodule

// File: rtl/nios2_system_v0_done_bit_in.sv
// Done/status input port from the convolution filter to the Nios II.
// Synchronises each input bit, latches the configured edge in an
// edge-capture register and raises irq for unmasked captured edges.
// Optional macro DONE_BIT_BITCLEAR_EN: write-1-to-clear on the capture
// register; when undefined any capture write clears every bit.
module nios2_system_v0_done_bit_in
  import nios2_system_v0_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_EN      = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  nios2_system_v0_done_bit_in_if.slave    bus,
  input  logic [DATA_WIDTH-1:0]           in_port
);

  logic [DATA_WIDTH-1:0] sync_bus;
  logic [DATA_WIDTH-1:0] edge_bus;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] cap;
  logic [DATA_WIDTH-1:0] clr;
  logic [31:0]           rd_next;
  logic                  wr;
  logic                  unused;

  // Only the low DATA_WIDTH bits of writedata are meaningful
  assign unused = ^bus.writedata;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    nios2_system_v0_sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
    ) u_det (
      .clk        (clk),
      .reset      (reset),
      .din        (in_port[i]),
      .sync       (sync_bus[i]),
      .edge_pulse (edge_bus[i])
    );
  end

  assign wr = bus.chipselect & ~bus.write_n;

  // Capture clear vector from a write to the capture register
  always_comb begin
    clr = '0;
    if (wr && bus.address == PIO_ADDR_CAPTURE) begin
`ifdef DONE_BIT_BITCLEAR_EN
      clr = bus.writedata[DATA_WIDTH-1:0];
`else
      clr = '1;
`endif
    end
  end

  // Read mux; unused bits and the reserved offset read as zero
  always_comb begin
    rd_next = '0;
    case (bus.address)
      PIO_ADDR_DATA:    rd_next[DATA_WIDTH-1:0] = sync_bus;
      PIO_ADDR_MASK:    rd_next[DATA_WIDTH-1:0] = mask;
      PIO_ADDR_CAPTURE: rd_next[DATA_WIDTH-1:0] = cap;
      default:          rd_next = '0;
    endcase
  end

  // Mask, edge capture (set dominates clear), registered read data and irq
  always_ff @(posedge clk) begin
    if (reset) begin
      mask         <= '0;
      cap          <= '0;
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      if (IRQ_EN != 0 && wr && bus.address == PIO_ADDR_MASK)
        mask <= bus.writedata[DATA_WIDTH-1:0];
      cap          <= edge_bus | (cap & ~clr);
      bus.readdata <= rd_next;
      bus.irq      <= (IRQ_EN != 0) ? |(cap & mask) : 1'b0;
    end
  end

endmodule

// File: tb/tb_nios2_system_v0_done_bit_in.sv
// Directed bench for the done-bit input port (4 bits, rising edge,
// two-stage synchroniser, irq enabled).
module tb_nios2_system_v0_done_bit_in;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_port;
  int         checks = 0;
  int         failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  nios2_system_v0_done_bit_in_if bus ();

  nios2_system_v0_done_bit_in #(
    .DATA_WIDTH  (4),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .IRQ_EN      (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected read result, advance one clock, then score it
  task automatic expect_next(input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, bus.readdata, e);
  endtask

  task automatic read_reg(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus.address = addr;
    expect_next(exp, tag);
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bitclr_exp;
`ifdef DONE_BIT_BITCLEAR_EN
    bitclr_exp = 32'hA;
`else
    bitclr_exp = 32'h0;
`endif
    reset          = 1'b1;
    in_port        = 4'h0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset
    repeat (3) tick();
    reset = 1'b0;
    check("irq_reset", {31'd0, bus.irq}, 32'd0);
    check("readdata_reset", bus.readdata, 32'd0);
    read_reg(2'd0, 32'h0, "rst_data");
    read_reg(2'd1, 32'h0, "rst_rsvd");
    read_reg(2'd2, 32'h0, "rst_mask");
    read_reg(2'd3, 32'h0, "rst_cap");

    // Rising detect with exact latency
    bus.address = 2'd3;
    in_port = 4'h1;
    tick();
    tick();
    expect_next(32'h0, "cap_not_early");
    expect_next(32'h1, "cap_rise");
    read_reg(2'd0, 32'h1, "data_sync");
    read_reg(2'd2, 32'h0, "mask_zero");

    // IRQ assert and clear
    write_reg(2'd3, 32'hF);
    write_reg(2'd2, 32'h1);
    in_port = 4'h0;
    repeat (4) tick();
    check("irq_idle", {31'd0, bus.irq}, 32'd0);
    in_port = 4'h1;
    tick();
    tick();
    tick();
    check("irq_not_early", {31'd0, bus.irq}, 32'd0);
    tick();
    check("irq_assert", {31'd0, bus.irq}, 32'd1);
    write_reg(2'd3, 32'hF);
    check("irq_pipe_on_clear", {31'd0, bus.irq}, 32'd1);
    tick();
    check("irq_cleared", {31'd0, bus.irq}, 32'd0);
    read_reg(2'd3, 32'h0, "cap_cleared");

    // Set dominates clear
    in_port = 4'h0;
    repeat (4) tick();
    in_port = 4'h1;
    repeat (4) tick();
    check("irq_preset", {31'd0, bus.irq}, 32'd1);
    in_port = 4'h0;
    repeat (4) tick();
    in_port = 4'h1;
    tick();
    tick();
    write_reg(2'd3, 32'hF);
    check("irq_set_dom", {31'd0, bus.irq}, 32'd1);
    read_reg(2'd3, 32'h1, "cap_set_dom");
    check("irq_set_dom_hold", {31'd0, bus.irq}, 32'd1);

    // Bit-clear behaviour and width/RO boundaries
    in_port = 4'h0;
    repeat (4) tick();
    in_port = 4'hF;
    repeat (4) tick();
    read_reg(2'd3, 32'hF, "cap_all");
    read_reg(2'd0, 32'hF, "data_all");
    write_reg(2'd3, 32'h5);
    read_reg(2'd3, bitclr_exp, "cap_bitclear");
    write_reg(2'd2, 32'hFFFF_FFF1);
    read_reg(2'd2, 32'h1, "mask_upper_ignored");
    write_reg(2'd1, 32'hFFFF_FFFF);
    read_reg(2'd1, 32'h0, "rsvd_reads_zero");
    write_reg(2'd0, 32'h0);
    read_reg(2'd0, 32'hF, "data_read_only");

    // Reset mid-operation
    write_reg(2'd3, 32'hF);
    in_port = 4'h0;
    repeat (4) tick();
    in_port = 4'h1;
    repeat (5) tick();
    check("irq_before_rst", {31'd0, bus.irq}, 32'd1);
    read_reg(2'd3, 32'h1, "cap_before_rst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("irq_after_rst", {31'd0, bus.irq}, 32'd0);
    check("readdata_after_rst", bus.readdata, 32'd0);
    read_reg(2'd2, 32'h0, "mask_after_rst");
    bus.address = 2'd3;
    expect_next(32'h0, "cap_after_rst");
    expect_next(32'h0, "cap_rst_not_early");
    expect_next(32'h1, "cap_rst_reedge");
    check("irq_masked_after_rst", {31'd0, bus.irq}, 32'd0);
    tick();
    check("irq_masked_hold", {31'd0, bus.irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
